// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// One shift-add multiply or restoring-divide iteration is done per clock.
// The first iteration runs on the accept edge, so done arrives 33 edges
// after the start cycle. Sign fixup happens in a dedicated FIX cycle.
//
// Handshake: an op is accepted on a rising edge where state is IDLE,
// start=1 and flush=0. From the accepting cycle through FIX, stall holds
// the upstream pipeline. The inputs are sampled only at accept. done is a
// one-cycle pulse with result valid, and result holds until the next done.
// There is no backpressure on done.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int SW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [SW-1:0]   step;
    logic [2:0]      op;
    logic            neg;
    logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] acc_hi;   // product high word or partial remainder
    logic [XLEN-1:0] acc_lo;   // multiplier/product low word or quotient

    // Multiply iteration: add the multiplicand if the multiplier LSB is set,
    // then shift the 2*XLEN product right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo,
                                                    input logic [XLEN-1:0] m);
        logic [XLEN:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {sum, lo[XLEN-1:1]};
    endfunction

    // Restoring divide iteration. The shifted remainder is XLEN+1 bits wide.
    // After a successful subtract the value is below the divisor, so it fits
    // back into XLEN bits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo,
                                                    input logic [XLEN-1:0] d);
        logic [XLEN:0]   r_sh;
        logic            ge;
        logic [XLEN-1:0] rem_n;
        r_sh  = {hi, lo[XLEN-1]};
        ge    = (r_sh >= {1'b0, d});
        rem_n = ge ? (r_sh[XLEN-1:0] - d) : r_sh[XLEN-1:0];
        return {rem_n, lo[XLEN-2:0], ge};
    endfunction

    logic            is_div_in, sgn_a, sgn_b, neg_a, neg_b, neg_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic [XLEN-1:0] src_hi, src_lo, src_m;
    logic            src_div;
    logic [2*XLEN-1:0] nxt, prod, prod_f;
    logic [XLEN-1:0] fix_res;

    // Decode the incoming op: operand signs, magnitudes and special divides.
    always_comb begin
        is_div_in   = func3[2];
        sgn_a       = is_div_in ? ~func3[0] : (func3 != 3'b011);
        sgn_b       = is_div_in ? ~func3[0] : ~func3[1];
        neg_a       = sgn_a & rs1[XLEN-1];
        neg_b       = sgn_b & rs2[XLEN-1];
        mag_a       = neg_a ? (~rs1 + 1'b1) : rs1;
        mag_b       = neg_b ? (~rs2 + 1'b1) : rs2;
        // The remainder follows the dividend; the quotient and product use the XOR of the signs.
        neg_in      = (is_div_in && func3[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero    = is_div_in && (rs2 == '0);
        div_ovf     = is_div_in && !func3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        special_res = '0;
        if (div_zero)
            special_res = func3[1] ? rs1 : '1;
        else if (div_ovf)
            special_res = func3[1] ? '0 : MIN_NEG;
    end

    // Iteration datapath. In IDLE it runs on fresh magnitudes, otherwise on the accumulators.
    always_comb begin
        src_hi  = acc_hi;
        src_lo  = acc_lo;
        src_m   = opnd;
        src_div = op[2];
        if (state == S_IDLE) begin
            src_hi  = '0;
            src_lo  = is_div_in ? mag_a : mag_b;
            src_m   = is_div_in ? mag_b : mag_a;
            src_div = is_div_in;
        end
        nxt = src_div ? div_step(src_hi, src_lo, src_m) : mul_step(src_hi, src_lo, src_m);
    end

    // Sign fixup and word select for the FIX cycle.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_f = neg ? (~prod + 1'b1) : prod;
        case (op)
            3'b000:         fix_res = prod_f[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         fix_res = prod_f[2*XLEN-1:XLEN];
            3'b100, 3'b101: fix_res = neg ? (~acc_lo + 1'b1) : acc_lo;
            default:        fix_res = neg ? (~acc_hi + 1'b1) : acc_hi;
        endcase
    end

    // Sequencer: accept, iterate, fix up, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            step   <= '0;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op   <= func3;
                        neg  <= neg_in;
                        opnd <= src_m;
                        step <= '0;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else begin
                            acc_hi <= nxt[2*XLEN-1:XLEN];
                            acc_lo <= nxt[XLEN-1:0];
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= nxt[2*XLEN-1:XLEN];
                        acc_lo <= nxt[XLEN-1:0];
                        step   <= step + 1'b1;
                        // Iteration 0 ran at accept, so this is the last one.
                        if (step == SW'(XLEN-2))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_res;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state == S_CALC) || (state == S_FIX);
        done      = (state == S_DONE);
        stall     = ((state == S_IDLE) && start && !flush) || busy;
        dbg_state = state;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus hand-written flush/reset/hold sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int tests;
    int fails;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        bit          hold;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // Run one op. Cycle 1 is the start cycle. Also samples one cycle after done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output logic [31:0] res, output int done_cyc,
                         output int stall_cnt, output int done_w);
        int cyc;
        res = 'x; done_cyc = 0; stall_cnt = 0; done_w = 0;
        @(negedge clk);
        start = 1'b1; func3 = f; rs1 = a; rs2 = b;
        cyc = 1;
        #1;
        if (stall) stall_cnt++;
        if (done) done_w++;
        while (done_cyc == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            #1;
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = cyc;
                done_w++;
                res = result;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        if (done) done_w++;
        if (stall) stall_cnt++;
    endtask

    initial begin
        logic [31:0] res, prev;
        int dc, sc, dw, seen;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 34};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 34};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        1'b0, 32'd14,       34};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        1'b0, 32'd2,        34};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 2};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        1'b1, 32'd5,        2};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 2};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        2};
        vecs[12] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        34};
        vecs[13] = '{3'b000, 32'h12345678, 32'h10,       1'b0, 32'h23456780, 34};
        vecs[14] = '{3'b011, 32'h12345678, 32'h10,       1'b0, 32'h00000001, 34};
        vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 34};
        vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,        34};
        vecs[17] = '{3'b111, 32'hFFFFFFFF, 32'h10,       1'b0, 32'hF,        34};

        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0; flush = 1'b0;

        // Reset state.
        #12;
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_stall",  {31'd0, stall}, 32'd0);
        check("reset_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hold, res, dc, sc, dw);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].lat);
            check($sformatf("v%0d_stall_cycles", i), sc, vecs[i].lat - 1);
            check($sformatf("v%0d_done_width", i), dw, 32'd1);
        end
        prev = vecs[NV-1].exp;

        // Flush on the 10th CALC cycle.
        @(negedge clk);
        start = 1'b1; func3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_in_calc", {31'd0, stall}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy",   {31'd0, busy},  32'd0);
        check("flush_stall",  {31'd0, stall}, 32'd0);
        check("flush_result", result,         prev);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        check("flush_no_done", seen, 32'd0);
        check("flush_result_held", result, prev);
        do_op(3'b000, 32'd3, 32'd4, 1'b0, res, dc, sc, dw);
        check("post_flush_mul", res, 32'd12);
        check("post_flush_done_cycle", dc, 32'd34);

        // Flush together with start in IDLE: nothing is accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'b101; rs1 = 32'd9; rs2 = 32'd0;
        #1;
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        check("idle_flush_done", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; func3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   {31'd0, busy},  32'd0);
        check("arst_done",   {31'd0, done},  32'd0);
        check("arst_stall",  {31'd0, stall}, 32'd0);
        check("arst_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        check("arst_no_done", seen, 32'd0);
        do_op(3'b111, 32'd100, 32'd7, 1'b0, res, dc, sc, dw);
        check("post_arst_remu", res, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
